// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer: dual-lane fetch-to-decode instruction queue; optional intra-pair RAW split under BUFFER_DEP_CHECK_EN
module fetch_issue_buffer #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Fetch_Valid_0,
  input  logic                  Fetch_Valid_1,
  input  logic [INST_WIDTH-1:0] Fetch_Inst_0,
  input  logic [INST_WIDTH-1:0] Fetch_Inst_1,
  input  logic [PC_WIDTH-1:0]   Fetch_Pc_0,
  input  logic [PC_WIDTH-1:0]   Fetch_Pc_1,
  output logic                  Buffer_Ready,
  input  logic                  DecodeHazard_StallReq,
  input  logic                  Flush,
  output logic                  Buffer_Valid_0,
  output logic                  Buffer_Valid_1,
  output logic [INST_WIDTH-1:0] Buffer_Inst_0,
  output logic [INST_WIDTH-1:0] Buffer_Inst_1,
  output logic [PC_WIDTH-1:0]   Buffer_Pc_0,
  output logic [PC_WIDTH-1:0]   Buffer_Pc_1,
  output logic [DEPTH_LOG2:0]   Buffer_Count
);
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);
  localparam logic [DEPTH_LOG2:0] READY_MAX = (DEPTH_LOG2+1)'(DEPTH - 2);
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d, head_1, tail_1;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]            push_n, pop_n;
  logic [INST_WIDTH-1:0] h0, h1;
  logic                  dep;
  assign head_1 = head_q + DEPTH_LOG2'(1);
  assign tail_1 = tail_q + DEPTH_LOG2'(1);
  assign h0 = inst_q[head_q];
  assign h1 = inst_q[head_1];
`ifdef BUFFER_DEP_CHECK_EN
  // Lane 1 is held back when it reads the register lane 0 writes; stores and branches write no rd.
  assign dep = h0[6:0] != 7'b0100011 && h0[6:0] != 7'b1100011 && h0[11:7] != 5'd0 &&
               (h1[19:15] == h0[11:7] || h1[24:20] == h0[11:7]);
`else
  assign dep = 1'b0;
`endif
  assign Buffer_Ready   = count_q <= READY_MAX;
  assign Buffer_Count   = count_q;
  assign Buffer_Valid_0 = count_q != '0;
  assign Buffer_Valid_1 = count_q >= (DEPTH_LOG2+1)'(2) && !dep;
  assign Buffer_Inst_0  = Buffer_Valid_0 ? h0 : NOP;
  assign Buffer_Inst_1  = Buffer_Valid_1 ? h1 : NOP;
  assign Buffer_Pc_0    = Buffer_Valid_0 ? pc_q[head_q] : '0;
  assign Buffer_Pc_1    = Buffer_Valid_1 ? pc_q[head_1] : '0;
  // Next-state pointers and occupancy; flush overrides push, pop and stall.
  always_comb begin
    push_n  = Buffer_Ready ? {1'b0, Fetch_Valid_0} + {1'b0, Fetch_Valid_1} : 2'd0;
    pop_n   = DecodeHazard_StallReq ? 2'd0 : {1'b0, Buffer_Valid_0} + {1'b0, Buffer_Valid_1};
    head_d  = Flush ? '0 : head_q + DEPTH_LOG2'(pop_n);
    tail_d  = Flush ? '0 : tail_q + DEPTH_LOG2'(push_n);
    count_d = Flush ? '0 : count_q + (DEPTH_LOG2+1)'(push_n) - (DEPTH_LOG2+1)'(pop_n);
  end
  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage is never reset; lane 0 lands at tail, lane 1 at tail+1.
  always_ff @(posedge clk) begin
    if (rst_n && !Flush && push_n != 2'd0) begin
      inst_q[tail_q] <= Fetch_Inst_0;
      pc_q[tail_q]   <= Fetch_Pc_0;
    end
    if (rst_n && !Flush && push_n == 2'd2) begin
      inst_q[tail_1] <= Fetch_Inst_1;
      pc_q[tail_1]   <= Fetch_Pc_1;
    end
  end
endmodule

// File: tb/tb_fetch_issue_buffer.sv
// tb_fetch_issue_buffer: scoreboard-driven bench for fetch_issue_buffer
module tb_fetch_issue_buffer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        fv0 = 0, fv1 = 0, stall = 0, flush = 0;
  logic [31:0] fi0 = 0, fi1 = 0, fp0 = 0, fp1 = 0;
  logic        ready, bv0, bv1;
  logic [31:0] bi0, bi1, bp0, bp1;
  logic [3:0]  cnt;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] sb [$];
  logic [63:0] e;

  fetch_issue_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .Fetch_Valid_0(fv0), .Fetch_Valid_1(fv1),
    .Fetch_Inst_0(fi0), .Fetch_Inst_1(fi1),
    .Fetch_Pc_0(fp0), .Fetch_Pc_1(fp1),
    .Buffer_Ready(ready), .DecodeHazard_StallReq(stall), .Flush(flush),
    .Buffer_Valid_0(bv0), .Buffer_Valid_1(bv1),
    .Buffer_Inst_0(bi0), .Buffer_Inst_1(bi1),
    .Buffer_Pc_0(bp0), .Buffer_Pc_1(bp1),
    .Buffer_Count(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v0, input logic v1, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    fv0 = v0; fv1 = v1; fi0 = i0; fp0 = p0; fi1 = i1; fp1 = p1;
  endtask

  function automatic logic [31:0] inert(input int k);
    return {12'(k), 20'h00013};
  endfunction

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    n_tests++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL reset_v0 got %b want 0", bv0); end
    n_tests++; if (bv1 !== 1'b0) begin n_fail++; $display("FAIL reset_v1 got %b want 0", bv1); end
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_tests++; if (bi0 !== 32'h13 || bi1 !== 32'h13) begin n_fail++; $display("FAIL reset_nop got %h/%h want 00000013", bi0, bi1); end
    n_tests++; if (bp0 !== 32'h0 || bp1 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0", bp0, bp1); end
  endtask

  task automatic test_pair();
    offer(1, 1, 32'h00500093, 32'h0, 32'h00600113, 32'h4);
    sb.push_back({32'h00500093, 32'h0});
    sb.push_back({32'h00600113, 32'h4});
    tick();
    offer(0, 0, 0, 0, 0, 0);
    n_tests++; if (bv0 !== 1'b1 || bv1 !== 1'b1) begin n_fail++; $display("FAIL pair_valid got %b%b want 11", bv0, bv1); end
    e = sb.pop_front();
    n_tests++; if ({bi0, bp0} !== e) begin n_fail++; $display("FAIL pair_lane0 got %h want %h", {bi0, bp0}, e); end
    e = sb.pop_front();
    n_tests++; if ({bi1, bp1} !== e) begin n_fail++; $display("FAIL pair_lane1 got %h want %h", {bi1, bp1}, e); end
    tick();
    n_tests++; if (cnt !== 4'd0 || bv0 !== 1'b0 || bv1 !== 1'b0) begin n_fail++; $display("FAIL pair_drain got cnt=%0d v=%b%b want 0 00", cnt, bv0, bv1); end
  endtask

  task automatic test_fill();
    int exp_cnt;
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      offer(1, 1, inert(2*k+1), 32'h100 + 8*k, inert(2*k+2), 32'h104 + 8*k);
      sb.push_back({inert(2*k+1), 32'h100 + 8*k});
      sb.push_back({inert(2*k+2), 32'h104 + 8*k});
      tick();
    end
    n_tests++; if (cnt !== 4'd8 || ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b want 8 0", cnt, ready); end
    offer(1, 1, inert(99), 32'h900, inert(98), 32'h904);
    tick();
    offer(0, 0, 0, 0, 0, 0);
    n_tests++; if (cnt !== 4'd8) begin n_fail++; $display("FAIL fill_reject got cnt=%0d want 8", cnt); end
    stall = 0;
    exp_cnt = 8;
    while (exp_cnt > 0) begin
      n_tests++; if (cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL drain_count got %0d want %0d", cnt, exp_cnt); end
      n_tests++; if (ready !== (exp_cnt <= 6)) begin n_fail++; $display("FAIL drain_ready got %b want %b at %0d", ready, exp_cnt <= 6, exp_cnt); end
      for (int l = 0; l < 2; l++) begin
        e = sb.size() != 0 ? sb.pop_front() : 64'hx;
        n_tests++;
        if ((l == 0 ? {bv0, bi0, bp0} : {bv1, bi1, bp1}) !== {1'b1, e}) begin
          n_fail++; $display("FAIL drain_lane%0d got %h want %h", l, l == 0 ? {bi0, bp0} : {bi1, bp1}, e);
        end
      end
      tick();
      exp_cnt -= 2;
    end
    n_tests++; if (cnt !== 4'd0 || bv0 !== 1'b0) begin n_fail++; $display("FAIL drain_empty got cnt=%0d v0=%b want 0 0", cnt, bv0); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 12; k++) begin
      offer(1, 0, inert(200 + k), 32'h2000 + 4*k, 0, 0);
      sb.push_back({inert(200 + k), 32'h2000 + 4*k});
      tick();
      n_tests++; if (cnt !== 4'd1 || bv1 !== 1'b0) begin n_fail++; $display("FAIL wrap_single got cnt=%0d v1=%b want 1 0", cnt, bv1); end
      e = sb.size() != 0 ? sb.pop_front() : 64'hx;
      n_tests++; if ({bv0, bi0, bp0} !== {1'b1, e}) begin n_fail++; $display("FAIL wrap_lane0_%0d got %h want %h", k, {bi0, bp0}, e); end
    end
    offer(0, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_end got cnt=%0d want 0", cnt); end
  endtask

  task automatic test_flush();
    stall = 1;
    offer(1, 1, inert(300), 32'h3000, inert(301), 32'h3004); tick();
    offer(1, 1, inert(302), 32'h3008, inert(303), 32'h300c); tick();
    offer(1, 0, inert(304), 32'h3010, 0, 0); tick();
    n_tests++; if (cnt !== 4'd5) begin n_fail++; $display("FAIL flush_pre got cnt=%0d want 5", cnt); end
    offer(1, 1, inert(305), 32'h3014, inert(306), 32'h3018);
    flush = 1;
    tick();
    flush = 0; stall = 0;
    offer(0, 0, 0, 0, 0, 0);
    n_tests++; if (cnt !== 4'd0 || bv0 !== 1'b0) begin n_fail++; $display("FAIL flush_clear got cnt=%0d v0=%b want 0 0", cnt, bv0); end
    tick();
    n_tests++; if (cnt !== 4'd0 || bv0 !== 1'b0) begin n_fail++; $display("FAIL flush_absent got cnt=%0d v0=%b want 0 0", cnt, bv0); end
  endtask

  task automatic test_dep();
    offer(1, 1, 32'h00500093, 32'h400, 32'h00108133, 32'h404);
    sb.push_back({32'h00500093, 32'h400});
    sb.push_back({32'h00108133, 32'h404});
    tick();
    offer(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if ({bv0, bi0, bp0} !== {1'b1, e}) begin n_fail++; $display("FAIL dep_lane0 got %h want %h", {bi0, bp0}, e); end
    e = sb.pop_front();
`ifdef BUFFER_DEP_CHECK_EN
    n_tests++; if (bv1 !== 1'b0 || bi1 !== 32'h13) begin n_fail++; $display("FAIL dep_withheld got v1=%b i1=%h want 0 00000013", bv1, bi1); end
    tick();
    n_tests++; if ({bv0, bi0, bp0} !== {1'b1, e} || cnt !== 4'd1) begin n_fail++; $display("FAIL dep_second got %h cnt=%0d want %h 1", {bi0, bp0}, cnt, e); end
`else
    n_tests++; if ({bv1, bi1, bp1} !== {1'b1, e}) begin n_fail++; $display("FAIL dep_lane1 got %h want %h", {bi1, bp1}, e); end
`endif
    tick();
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL dep_drain got cnt=%0d want 0", cnt); end
  endtask

  task automatic test_store();
    offer(1, 1, 32'h00112023, 32'h500, 32'h00108133, 32'h504);
    sb.push_back({32'h00112023, 32'h500});
    sb.push_back({32'h00108133, 32'h504});
    tick();
    offer(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if ({bv0, bi0, bp0} !== {1'b1, e}) begin n_fail++; $display("FAIL store_lane0 got %h want %h", {bi0, bp0}, e); end
    e = sb.pop_front();
    n_tests++; if ({bv1, bi1, bp1} !== {1'b1, e}) begin n_fail++; $display("FAIL store_lane1 got %b %h want 1 %h", bv1, {bi1, bp1}, e); end
    tick();
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL store_drain got cnt=%0d want 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_fill();
    test_wrap();
    test_flush();
    test_dep();
    test_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
